// File: rtl/egg_timer_pkg.sv
// egg_timer_pkg: shared FSM state encoding, BCD digit limits and BCD
// increment/decrement helpers for the egg timer countdown controller.
package egg_timer_pkg;

  localparam int DIGIT_W = 4;
  localparam int BYTE_W  = 2 * DIGIT_W;

  localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  // Two-digit BCD +1 over 00..59, wrapping 59 -> 00.
  function automatic logic [BYTE_W-1:0] bcd_inc(input logic [BYTE_W-1:0] v);
    logic [DIGIT_W-1:0] t;
    logic [DIGIT_W-1:0] o;
    t = v[BYTE_W-1:DIGIT_W];
    o = v[DIGIT_W-1:0];
    if (o == ONES_MAX) begin
      o = '0;
      t = (t == TENS_MAX) ? '0 : t + 1'b1;
    end else begin
      o = o + 1'b1;
    end
    return {t, o};
  endfunction

  // Two-digit BCD -1 over 00..59 with ones borrow; 00 wraps to 59.
  function automatic logic [BYTE_W-1:0] bcd_dec(input logic [BYTE_W-1:0] v);
    logic [DIGIT_W-1:0] t;
    logic [DIGIT_W-1:0] o;
    t = v[BYTE_W-1:DIGIT_W];
    o = v[DIGIT_W-1:0];
    if (o == '0) begin
      o = ONES_MAX;
      t = (t == '0) ? TENS_MAX : t - 1'b1;
    end else begin
      o = o - 1'b1;
    end
    return {t, o};
  endfunction

endpackage

// File: rtl/egg_timer_ctrl_tick_gen.sv
// egg_tick_gen: free-running divider producing a registered one-cycle tick
// every DIV enabled cycles. clr or a low en parks the count at 0.
module egg_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic          tick_q;

  // Count 0..DIV-1 while enabled; tick registers on the terminal count.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (clr || !en) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q  <= (count_q == LAST);
      count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: countdown controller holding MM:SS as four BCD digits,
// sequencing the tick divider and raising the alarm at 00:00.
// Optional feature macro ALARM_TIMEOUT_EN: alarm auto-clears after
// ALARM_SECS ticks; without it ALARM waits for start_stop or clear.
//
// Handshake: all control inputs are single-cycle pulses with no back
// pressure; each pulse is consumed on the edge that samples it, with
// priority clear > start_stop > inc_*.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int ALARM_SECS = 30
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       alarm,
  output logic       tick,
  output logic [1:0] state_dbg
);

  state_t state_q, state_d;

  logic [DIGIT_W-1:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [DIGIT_W-1:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;

  logic [BYTE_W-1:0] min_cur, sec_cur, min_nxt, sec_nxt;
  logic [BYTE_W-1:0] min_dec, sec_dec;
  logic              time_zero, dec_zero;

  logic div_tick, div_en, div_clr;

  assign min_cur   = {min_tens_q, min_ones_q};
  assign sec_cur   = {sec_tens_q, sec_ones_q};
  assign time_zero = (min_cur == '0) && (sec_cur == '0);

  // One-second countdown step: borrow from minutes when seconds are 00.
  always_comb begin
    min_dec = min_cur;
    sec_dec = sec_cur;
    if (sec_cur != '0) begin
      sec_dec = bcd_dec(sec_cur);
    end else begin
      min_dec = bcd_dec(min_cur);
      sec_dec = {TENS_MAX, ONES_MAX};
    end
  end

  assign dec_zero = (min_dec == '0) && (sec_dec == '0);

`ifdef ALARM_TIMEOUT_EN
  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SECS - 1);
  logic [5:0] alarm_cnt_q, alarm_cnt_d;
  logic       alarm_expire;

  // Counts ticks spent in ALARM; restarts from 0 on every ALARM entry.
  always_comb begin
    alarm_cnt_d = '0;
    if (state_q == ALARM && div_tick) alarm_cnt_d = alarm_cnt_q + 1'b1;
    else if (state_q == ALARM)        alarm_cnt_d = alarm_cnt_q;
  end

  assign alarm_expire = div_tick && (alarm_cnt_q == ALARM_LAST);

  // Alarm timeout counter register.
  always_ff @(posedge clk_in) begin
    if (!reset) alarm_cnt_q <= '0;
    else        alarm_cnt_q <= alarm_cnt_d;
  end
`else
  logic unused_alarm_secs;
  assign unused_alarm_secs = (ALARM_SECS < 1);
`endif

  // Next-state and time update; clear beats start_stop beats inc_*.
  always_comb begin
    state_d = state_q;
    min_nxt = min_cur;
    sec_nxt = sec_cur;
    case (state_q)
      IDLE: begin
        if (clear) begin
          min_nxt = '0;
          sec_nxt = '0;
        end else if (start_stop) begin
          if (!time_zero) state_d = RUN;
        end else begin
          if (inc_min) min_nxt = bcd_inc(min_cur);
          if (inc_sec) sec_nxt = bcd_inc(sec_cur);
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
          min_nxt = '0;
          sec_nxt = '0;
        end else begin
          if (div_tick) begin
            min_nxt = min_dec;
            sec_nxt = sec_dec;
          end
          if (div_tick && dec_zero) state_d = ALARM;
          else if (start_stop)      state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          min_nxt = '0;
          sec_nxt = '0;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      ALARM: begin
        min_nxt = '0;
        sec_nxt = '0;
        if (clear || start_stop) state_d = IDLE;
`ifdef ALARM_TIMEOUT_EN
        else if (alarm_expire)   state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        min_nxt = '0;
        sec_nxt = '0;
      end
    endcase
    {min_tens_d, min_ones_d} = min_nxt;
    {sec_tens_d, sec_ones_d} = sec_nxt;
  end

  // State and BCD digit registers.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q    <= IDLE;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  // Divider follows the next state so no tick escapes into PAUSE/IDLE,
  // and restarts a full second on every entry into RUN.
`ifdef ALARM_TIMEOUT_EN
  assign div_en = (state_d == RUN) || (state_d == ALARM);
`else
  assign div_en = (state_d == RUN);
`endif
  assign div_clr = (state_d == RUN) && (state_q != RUN);

  egg_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (div_en),
    .clr    (div_clr),
    .tick   (div_tick)
  );

  assign min_bcd   = min_cur;
  assign sec_bcd   = sec_cur;
  assign running   = (state_q == RUN);
  assign alarm     = (state_q == ALARM);
  assign tick      = div_tick;
  assign state_dbg = state_q;

endmodule

// File: doc/egg_timer_ctrl.md
# egg_timer_ctrl

Countdown controller for the egg timer: it holds the minutes and seconds setting and sequences the 1 Hz tick divider. It runs, pauses and clears the countdown, and raises the alarm when the count reaches 00:00. It sits between the debounced button pulses and the seven-segment display driver, which takes its BCD outputs directly.

## Interface
- TICK_DIV, 100_000_000: clk_in cycles per countdown tick (1 Hz at 100 MHz); must be ≥ 2.
- ALARM_SECS, 30: ticks the alarm stays up before auto-clear; used only under ALARM_TIMEOUT_EN.
- clk_in  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk_in.
- start_stop  in  1  single-cycle pulse, debounced upstream; toggles run/pause, acknowledges alarm.
- clear  in  1  single-cycle pulse; abort, return to IDLE at 00:00.
- inc_min  in  1  single-cycle pulse; minutes +1 (IDLE only).
- inc_sec  in  1  single-cycle pulse; seconds +1 (IDLE only).
- min_bcd  out  8  minutes, BCD {tens[7:4], ones[3:0]}, 00–59.
- sec_bcd  out  8  seconds, BCD {tens, ones}, 00–59.
- running  out  1  high in RUN.
- alarm  out  1  high in ALARM.
- tick  out  1  registered one-cycle pulse from divider (display blink / debug).

## Operation
- Time is stored as four BCD digit registers. There is no binary-to-BCD conversion. The tens digits are 0–5 and the ones digits are 0–9.
- FSM states are IDLE, RUN, PAUSE and ALARM. Reset state is IDLE.
- Input priority within a cycle: clear > start_stop > inc_*.
- IDLE:
  - inc_min: minutes wrap 59→00.
  - inc_sec: seconds wrap 59→00, with no carry into minutes.
  - inc_min and inc_sec in the same cycle: both apply.
  - start_stop with time ≠ 00:00 → RUN. With time 00:00 it is ignored and the FSM stays in IDLE.
  - clear → time 00:00.
- RUN:
  - On tick: if seconds ≠ 00, seconds −1 (BCD borrow ones 0→9, tens −1). Otherwise minutes −1 and seconds → 59.
  - If the post-decrement value is 00:00 → ALARM.
  - start_stop → PAUSE.
  - clear → IDLE, time 00:00.
  - inc_* ignored.
- PAUSE:
  - Time is frozen and tick is suppressed.
  - start_stop → RUN.
  - clear → IDLE, time 00:00.
  - inc_* ignored.
- ALARM:
  - Time reads 00:00 and alarm = 1.
  - start_stop or clear → IDLE.
- Divider:
  - The count runs 0..TICK_DIV−1 only in RUN, and also in ALARM when ALARM_TIMEOUT_EN is defined. It is held at 0 in all other states.
  - It is cleared on every transition into RUN, so each run or resume restarts the full second.
- Tick and start_stop in the same RUN cycle: the decrement applies and the FSM → PAUSE. If that decrement reaches 00:00, ALARM wins.
- Tick and clear in the same cycle: clear wins, time 00:00, no decrement.

## Timing
- Reset (reset = 0 at posedge): next cycle state = IDLE, min_bcd = 8'h00, sec_bcd = 8'h00, running = 0, alarm = 0, tick = 0, divider = 0.
- Reset overrides all inputs, including mid-RUN and mid-ALARM.
- All outputs are registered and update on the edge that samples the causing input, visible one cycle later.
- First tick after RUN entry: tick is high in the cycle TICK_DIV cycles after running first reads 1. The first decrement is visible one cycle after tick.
- From 00:01 in RUN, alarm rises one cycle after the tick pulse. running falls in the same cycle.
- Back-to-back pulses on consecutive cycles are each honoured.

## Configuration
- ALARM_TIMEOUT_EN defined:
  - In ALARM the divider keeps running.
  - A 6-bit tick counter (cleared on ALARM entry) returns the FSM to IDLE on the ALARM_SECS-th tick.
  - start_stop and clear still end ALARM early.
- ALARM_TIMEOUT_EN undefined: ALARM persists until start_stop or clear. The timeout counter is not built and ALARM_SECS is unused.

## Structure
- egg_timer_pkg: state encoding constants (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, ALARM = 2'd3), BCD digit width (4), limits TENS_MAX = 5, ONES_MAX = 9.
- One sub-module, egg_tick_gen:
  - Parameter DIV.
  - Ports clk_in, reset, en, clr, tick.
  - Counts while en, and produces a one-cycle tick at count DIV−1.
  - clr forces the count to 0.
- The FSM, BCD digit registers and optional alarm timeout live in egg_timer_ctrl.

## Test plan
- Reset then set: TICK_DIV = 4, pulse inc_min ×2 and inc_sec ×61 → min_bcd = 8'h02, sec_bcd = 8'h01, running = 0.
- Countdown with borrow: set 01:00, start_stop → running = 1; after 4 cycles tick, then sec_bcd = 8'h59 and min_bcd = 8'h00. After 59 further ticks, alarm = 1, running = 0, time 00:00.
- Pause/resume: set 00:05, run 2 ticks (00:03), start_stop → PAUSE. Hold 20 cycles with time still 00:03 and no tick. start_stop again → next decrement exactly 4 cycles after resume.
- Zero start and priority:
  - start_stop at 00:00 → stays IDLE.
  - clear and start_stop in the same cycle during RUN → IDLE at 00:00.
  - inc_sec during RUN → ignored.
- Mid-run reset: reset low for 1 cycle at 00:30 in RUN → all outputs zero, IDLE, no tick for ≥ 8 cycles.
- ALARM_TIMEOUT_EN with ALARM_SECS = 3: reach alarm, apply no input → IDLE after 3 ticks (12 cycles). With the macro undefined, alarm is still 1 after 100 cycles, and start_stop clears it.
